// File: rtl/zbt_pkg.sv
// Shared ZBT constants, loader state encoding and the 16+16 -> 36 bit packing helper.
package zbt_pkg;
  localparam int ZBT_DW = 36;
  localparam int ZBT_AW_DEF = 19;
  localparam logic [18:0] FULL_FRAME_WORDS   = 19'd307200;
  localparam logic [18:0] START_SCREEN_WORDS = 19'd260400;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  // Upper pixel sits in [33:18], lower in [15:0]; the two guard pairs stay zero.
  function automatic logic [ZBT_DW-1:0] pack_word(input logic [15:0] hi, input logic [15:0] lo);
    return {2'b00, hi, 2'b00, lo};
  endfunction
endpackage

// File: rtl/pack_fifo.sv
// Small synchronous FIFO for packed ZBT words; same-cycle push and pop allowed, flush empties it.
module pack_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wp, rp;
  logic             do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[PW-1:0]] <= din;
  end
endmodule

// File: rtl/flash_zbt_loader.sv
// Packs flash pixel word pairs into 36-bit ZBT words and writes them from a base address.
// Optional ZBT_LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted flash words.
module flash_zbt_loader
  import zbt_pkg::*;
#(
  parameter int ZBT_AW     = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ZBT_AW-1:0] base_addr,
  input  logic [18:0]       word_total,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  input  logic              zbt_ready,
  output logic              zbt_we,
  output logic [ZBT_AW-1:0] zbt_addr,
  output logic [35:0]       zbt_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
`ifdef ZBT_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);
  state_t      state;
  logic [18:0] cnt, total;
  logic        half;
  logic [15:0] upper;

  logic        accept, last, push, pop, full, empty;
  logic [35:0] push_data, head;

  assign accept    = (state == LOAD) && rd_valid && !start && (total != '0);
  assign last      = (cnt + 19'd1) == total;
  assign push      = accept && (half || last);
  assign push_data = half ? pack_word(upper, rd_data) : pack_word(rd_data, 16'h0000);
  assign pop       = !empty && zbt_ready && !start;

  pack_fifo #(.WIDTH(ZBT_DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      total     <= '0;
      half      <= 1'b0;
      upper     <= '0;
      zbt_we    <= 1'b0;
      zbt_addr  <= '0;
      zbt_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else if (start) begin
      state    <= LOAD;
      cnt      <= '0;
      total    <= word_total;
      half     <= 1'b0;
      zbt_we   <= 1'b0;
      zbt_addr <= base_addr;
      busy     <= 1'b1;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      zbt_we <= pop;
      if (pop)    zbt_wdata <= head;
      // zbt_addr is the write pointer; it advances once the write has been presented.
      if (zbt_we) zbt_addr  <= zbt_addr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      case (state)
        LOAD: begin
          // Empty image: nothing can be queued, so finish two cycles after start.
          if (total == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (accept) begin
            cnt  <= cnt + 19'd1;
            half <= !half;
            if (!half) upper <= rd_data;
            if (last)  state <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ZBT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start) checksum <= '0;
    else if (accept)    checksum <= checksum + rd_data;
  end
`endif
endmodule

// File: tb/tb_flash_zbt_loader.sv
// Directed bench for flash_zbt_loader: packing, latency, stalls, wrap, abort, reset and empty image.
module tb_flash_zbt_loader;
  logic        clk = 1'b0;
  logic        reset, start, rd_valid, zbt_ready;
  logic [18:0] base_addr, word_total;
  logic [15:0] rd_data;
  logic        zbt_we, busy, done, overflow;
  logic [18:0] zbt_addr;
  logic [35:0] zbt_wdata;
`ifdef ZBT_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int total_n = 0, bad_n = 0;
  int cyc = 0, sc = 0, rel;
  logic [18:0] wa[$];
  logic [35:0] wd[$];
  int          wc[$];

  flash_zbt_loader #(.ZBT_AW(19), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .word_total(word_total),
    .rd_valid(rd_valid), .rd_data(rd_data), .zbt_ready(zbt_ready), .zbt_we(zbt_we),
    .zbt_addr(zbt_addr), .zbt_wdata(zbt_wdata), .busy(busy), .done(done), .overflow(overflow)
`ifdef ZBT_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (zbt_we === 1'b1) begin
    wa.push_back(zbt_addr);
    wd.push_back(zbt_wdata);
    wc.push_back(cyc - sc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pk(input logic [15:0] u, input logic [15:0] l);
    return {2'b00, u, 2'b00, l};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete();
  endtask

  // start is driven in cycle 0; returns in cycle 1
  task automatic go(input logic [18:0] b, input logic [18:0] t);
    base_addr = b; word_total = t; start = 1'b1;
    tick();
    start = 1'b0;
    sc = cyc - 1;
  endtask

  task automatic feed(input logic [15:0] w);
    rd_valid = 1'b1; rd_data = w;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic wait_done(output int r);
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    chk("done_seen", done, 1'b1);
    r = (done === 1'b1) ? (cyc - sc) : -1;
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [18:0] a, input logic [35:0] d);
    chk({tag, "_addr"}, (k < wa.size()) ? 64'(wa[k]) : 64'hDEAD, 64'(a));
    chk({tag, "_data"}, (k < wd.size()) ? 64'(wd[k]) : 64'hDEAD, 64'(d));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_valid = 1'b0; rd_data = '0; zbt_ready = 1'b1;
    base_addr = '0; word_total = '0;
    tick(); tick();
    chk("rst_we", zbt_we, 1'b0);
    chk("rst_addr", zbt_addr, 19'h0);
    chk("rst_wdata", zbt_wdata, 36'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick();

    // four words, port always granted
    clr();
    go(19'h00100, 19'd4);
    chk("t4_busy_c1", busy, 1'b1);
    feed(16'h1111); feed(16'h2222); feed(16'h3333); feed(16'h4444);
    wait_done(rel);
    chk("t4_done_cyc", rel, 7);
    chk("t4_busy_low", busy, 1'b0);
    chk_wr("t4_w0", 0, 19'h00100, 36'h0_4444_2222);
    chk_wr("t4_w1", 1, 19'h00101, 36'h0_CCCC_4444);
    chk("t4_lat0", (wc.size() > 0) ? wc[0] : -1, 4);
    chk("t4_lat1", (wc.size() > 1) ? wc[1] : -1, 6);
    repeat (5) tick();
    chk("t4_nwr", wa.size(), 2);

    // odd total leaves a half word with zero lower pixel
    clr();
    go(19'h00040, 19'd3);
    feed(16'h1111); feed(16'h2222); feed(16'h3333);
    wait_done(rel);
    chk_wr("t3_w0", 0, 19'h00040, 36'h0_4444_2222);
    chk_wr("t3_w1", 1, 19'h00041, 36'h0_CCCC_0000);
    chk("t3_nwr", wa.size(), 2);

    // 20-cycle stall during 16 words: last four packed words dropped
    clr();
    zbt_ready = 1'b0;
    go(19'h00000, 19'd16);
    for (int i = 0; i < 16; i++) feed(16'h1000 + 16'(i));
    repeat (3) tick();
    zbt_ready = 1'b1;
    wait_done(rel);
    chk("ov20_flag", overflow, 1'b1);
    chk("ov20_nwr", wa.size(), 4);
    for (int k = 0; k < 4; k++)
      chk_wr("ov20_w", k, 19'(k), pk(16'h1000 + 16'(2*k), 16'h1000 + 16'(2*k+1)));

    // 10-cycle stall: push into full FIFO coincides with first pop, no loss
    clr();
    zbt_ready = 1'b0;
    go(19'h00300, 19'd16);
    chk("ov10_clr", overflow, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 9) zbt_ready = 1'b1;
      feed(16'h2000 + 16'(i));
    end
    wait_done(rel);
    chk("ov10_flag", overflow, 1'b0);
    chk("ov10_nwr", wa.size(), 8);
    for (int k = 0; k < 8; k++)
      chk_wr("ov10_w", k, 19'h00300 + 19'(k), pk(16'h2000 + 16'(2*k), 16'h2000 + 16'(2*k+1)));

    // address wrap
    clr();
    go(19'h7FFFF, 19'd4);
    feed(16'hA001); feed(16'hA002); feed(16'hA003); feed(16'hA004);
    wait_done(rel);
    chk_wr("wrap_w0", 0, 19'h7FFFF, pk(16'hA001, 16'hA002));
    chk_wr("wrap_w1", 1, 19'h00000, pk(16'hA003, 16'hA004));

    // abort mid-load with queued words and the port granted in the start cycle
    zbt_ready = 1'b0;
    go(19'h00000, 19'd10);
    for (int i = 0; i < 5; i++) feed(16'h5000 + 16'(i));
    clr();
    zbt_ready = 1'b1;
    go(19'h00200, 19'd2);
    feed(16'hAAAA); feed(16'hBBBB);
    wait_done(rel);
    chk("abort_nwr", wa.size(), 1);
    chk_wr("abort_w0", 0, 19'h00200, pk(16'hAAAA, 16'hBBBB));

    // empty image
    clr();
    go(19'h00010, 19'd0);
    chk("t0_busy_c1", busy, 1'b1);
    chk("t0_done_c1", done, 1'b0);
    wait_done(rel);
    chk("t0_done_cyc", rel, 2);
    repeat (3) tick();
    chk("t0_nwr", wa.size(), 0);

    // reset while draining with a write on the port
    zbt_ready = 1'b0;
    go(19'h00050, 19'd4);
    feed(16'h0101); feed(16'h0202); feed(16'h0303); feed(16'h0404);
    zbt_ready = 1'b1;
    tick();
    chk("rd_we_pre", zbt_we, 1'b1);
    reset = 1'b1;
    tick();
    chk("rd_we", zbt_we, 1'b0);
    chk("rd_addr", zbt_addr, 19'h0);
    chk("rd_wdata", zbt_wdata, 36'h0);
    chk("rd_busy", busy, 1'b0);
    chk("rd_done", done, 1'b0);
    chk("rd_ovf", overflow, 1'b0);
    reset = 1'b0;
    tick();

`ifdef ZBT_LOADER_CHECKSUM_EN
    go(19'h00000, 19'd2);
    feed(16'hFFFF); feed(16'h0002);
    wait_done(rel);
    chk("csum", checksum, 16'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
